sm83_regfile_mp: RTL and testbench
==================================

# sm83_regfile_mp

Parametrised SM83 register file: B/C/D/E/H/L, A, F, SP, PC, WZ temp pair, IR and IE.
- Provides a configurable number of 8-bit and 16-bit read ports, plus independent 8-bit, 16-bit, flag and PC write paths.
- Includes an integrated increment/decrement unit (IDU) for HL+/HL-, SP push/pop and pair INC/DEC.
- Sits between the decoder/sequencer and the ALU. Exports a full `reg_vec_t` snapshot to debug and the sequencer.

## Interface
Parameters:
- `NUM_R8_RD`, 2: number of 8-bit read ports.
- `NUM_R16_RD`, 2: number of 16-bit read ports.
- `BYPASS`, 1: 1 forwards same-cycle write data to reads; 0 reads registered state only.
- `POST_BOOT`, 1: 1 uses DMG post-boot reset values; 0 resets all registers to zero.

Ports:
- `clk` in 1: sole clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `r8_rd_sel` in `NUM_R8_RD`×`gp_r8_sel_t`: per-port 8-bit select; `REG_Z` reads temp Z.
- `r8_rd_data` out `NUM_R8_RD`×8: per-port read data.
- `r16_rd_sel` in `NUM_R16_RD`×`gp_r16_sel_t`: per-port pair select (BC/DE/HL/SP).
- `r16_rd_data` out `NUM_R16_RD`×16: per-port read data.
- `r8_wr_en` in 1, `r8_wr_sel` in `gp_r8_sel_t`, `r8_wr_data` in 8: 8-bit write; `REG_Z` writes Z.
- `r16_wr_en` in 1, `r16_wr_stk` in 1, `r16_wr_sel` in 2, `r16_wr_data` in 16: pair write.
  - `r16_wr_stk`=0 decodes `r16_wr_sel` as `gp_r16_sel_t` (index 3 = SP).
  - `r16_wr_stk`=1 decodes it as `stk_r16_sel_t` (index 3 = AF).
- `w_wr_en` in 1, `w_wr_data` in 8: write temp W.
- `f_wr_mask` in 4, `f_wr_data` in `flags_t`: per-flag write enable, ordered {z,n,h,c}.
- `idu_en` in 1, `idu_sel` in `gp_r16_sel_t`, `idu_dec` in 1: ±1 on the selected pair.
- `pc_wr_en` in 1, `pc_wr_data` in 16, `pc_inc` in 1: PC load or PC increment.
- `ir_wr_en` in 1, `ir_wr_data` in 8: instruction register load.
- `ie_wr_en` in 1, `ie_wr_data` in 8: IE load.
- `wz` out 16: {W,Z}, registered.
- `regs` out `reg_vec_t`: registered snapshot of all architectural registers.

## Operation
- **8-bit writes:** `r8_wr_sel`=`REG_A` writes A. `REG_Z` writes temp Z, never (HL).
- **F register:** F[3:0] is hard-wired to 0 on every write path.
- **Per-byte write priority:**
  - A/F/B–L bytes: `f_wr_mask` (F only) > `r8_wr` > `r16_wr` > `idu`.
  - SP: `r16_wr` > `idu`.
  - PC: `pc_wr_en` > `pc_inc`.
  - A lower-priority source is masked only on the bytes the higher source writes. Example: r8 H plus r16 HL in the same cycle gives H from r8 and L from r16.
- **IDU:** full 16-bit ±1 modulo 2^16; FFFF+1 = 0000 and 0000−1 = FFFF. It operates on the current registered pair value, not on forwarded data.
- **`pc_inc`:** adds 1 modulo 2^16.
- **Reads with `BYPASS`=1:** each read port returns the next-state value computed under the priority above (combinational forward). A pair read returns the byte-merged result.
- **Reads with `BYPASS`=0:** read ports return registered state.
- **Registered outputs:** `regs` and `wz` always show registered state, regardless of `BYPASS`.
- **Unused select encodings:** none; every encoding is defined.

## Timing
- Writes commit on the rising edge of `clk`. Registered outputs show the new value one cycle after the enable.
- Read-port latency: 0 cycles (combinational from select plus state or forward).
- **Reset values, asynchronous on `rst` high:**
  - `POST_BOOT`=1: A=01, F=B0, BC=0013, DE=00D8, HL=014D, SP=FFFE, PC=0100, WZ=0000, IR=00, IE=00.
  - `POST_BOOT`=0: all zero.
- **During reset:** all outputs reflect the reset values, and all write enables are ignored.
- **Reset mid-write:** the cycle's writes are discarded. The first write after `rst` deasserts commits on the first rising edge with `rst` low.
- **Combinational paths:**
  - No combinational path from write ports to read ports when `BYPASS`=0.
  - With `BYPASS`=1, the path is `*_wr_*` → `*_rd_data` only.

## Structure
- Add to `sm83_pkg`:
  - `idu_op_t` (IDU_NONE/IDU_INC/IDU_DEC).
  - `regfile_rst_t` constants, as a `reg_vec_t` localparam for each of the post-boot and zero reset sets.
  - Helper function `stk_to_idx`, mapping `stk_r16_sel_t` to the internal byte-pair index.
- Sub-module `sm83_idu`: combinational 16-bit ±1 (in 16, dec 1, out 16), shared by the IDU path and `pc_inc` as two instances.
- Next-state logic is a single per-byte priority mux feeding one `always_ff` with async reset.

## Test plan
- **Reset:** `POST_BOOT`=1, assert `rst` mid-cycle → `regs` = A=01, F=B0, BC=0013, DE=00D8, HL=014D, SP=FFFE, PC=0100, asynchronously, before the next edge.
- **HL+ wrap and IDU priority:** write HL=FFFF; then `idu_en`, `idu_sel`=HL, `idu_dec`=0 → HL=0000. Same cycle with `r16_wr` SP=1234 and IDU SP → SP=1234.
- **Byte merge:** same-cycle `r8_wr` H=AA and `r16_wr` HL=1234 → HL=AA34. Same-cycle `f_wr_mask`=1000 with z=0, plus `r16_wr_stk` AF=12FF → A=12, F=70.
- **Forwarding:** `BYPASS`=1, `r8_wr` B=5A with `r8_rd_sel[0]`=B → `r8_rd_data[0]`=5A in the same cycle. `BYPASS`=0 → old B in that cycle, 5A next cycle.
- **PC priority and wrap:** PC=FFFF with `pc_inc` → 0000. `pc_wr_en`=0200 together with `pc_inc` → 0200.
- **Temp pair:** `w_wr_en` W=C3 and `r8_wr` `REG_Z`=50 → `wz`=C350 next cycle, with no architectural register changed.

Source files
------------

// File: rtl/sm83_pkg.sv
// Shared SM83 register-file types, selector encodings and reset constants.
package sm83_pkg;

  typedef enum logic [2:0] {
    REG_B = 3'd0,
    REG_C = 3'd1,
    REG_D = 3'd2,
    REG_E = 3'd3,
    REG_H = 3'd4,
    REG_L = 3'd5,
    REG_Z = 3'd6,
    REG_A = 3'd7
  } gp_r8_sel_t;

  typedef enum logic [1:0] {
    R16_BC = 2'd0,
    R16_DE = 2'd1,
    R16_HL = 2'd2,
    R16_SP = 2'd3
  } gp_r16_sel_t;

  typedef enum logic [1:0] {
    STK_BC = 2'd0,
    STK_DE = 2'd1,
    STK_HL = 2'd2,
    STK_AF = 2'd3
  } stk_r16_sel_t;

  typedef enum logic [1:0] {
    IDU_NONE = 2'd0,
    IDU_INC  = 2'd1,
    IDU_DEC  = 2'd2
  } idu_op_t;

  // Internal pair index: gp encodings map 1:1, AF gets its own slot.
  typedef enum logic [2:0] {
    PAIR_BC = 3'd0,
    PAIR_DE = 3'd1,
    PAIR_HL = 3'd2,
    PAIR_SP = 3'd3,
    PAIR_AF = 3'd4
  } pair_idx_t;

  typedef struct packed {
    logic z;
    logic n;
    logic h;
    logic c;
  } flags_t;

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  f;
    logic [7:0]  b;
    logic [7:0]  c;
    logic [7:0]  d;
    logic [7:0]  e;
    logic [7:0]  h;
    logic [7:0]  l;
    logic [15:0] sp;
    logic [15:0] pc;
    logic [7:0]  w;
    logic [7:0]  z;
    logic [7:0]  ir;
    logic [7:0]  ie;
  } reg_vec_t;

  typedef reg_vec_t regfile_rst_t;

  localparam regfile_rst_t REGFILE_RST_BOOT = '{
    a: 8'h01, f: 8'hB0, b: 8'h00, c: 8'h13, d: 8'h00, e: 8'hD8,
    h: 8'h01, l: 8'h4D, sp: 16'hFFFE, pc: 16'h0100,
    w: 8'h00, z: 8'h00, ir: 8'h00, ie: 8'h00
  };

  localparam regfile_rst_t REGFILE_RST_ZERO = '0;

  function automatic pair_idx_t stk_to_idx(input stk_r16_sel_t sel);
    case (sel)
      STK_BC:  return PAIR_BC;
      STK_DE:  return PAIR_DE;
      STK_HL:  return PAIR_HL;
      default: return PAIR_AF;
    endcase
  endfunction

endpackage

// File: rtl/sm83_idu.sv
// Combinational 16-bit increment/decrement, wrapping modulo 2^16.
module sm83_idu (
  input  logic [15:0] i_in,
  input  logic        i_dec,
  output logic [15:0] o_out
);

  assign o_out = i_dec ? (i_in - 16'd1) : (i_in + 16'd1);

endmodule

// File: rtl/sm83_regfile_mp.sv
// SM83 register file with multi-port reads, prioritised per-byte writes and IDU.
module sm83_regfile_mp
  import sm83_pkg::*;
#(
  parameter int unsigned NUM_R8_RD  = 2,
  parameter int unsigned NUM_R16_RD = 2,
  parameter bit          BYPASS     = 1'b1,
  parameter bit          POST_BOOT  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  gp_r8_sel_t  r8_rd_sel   [NUM_R8_RD],
  output logic [7:0]  r8_rd_data  [NUM_R8_RD],
  input  gp_r16_sel_t r16_rd_sel  [NUM_R16_RD],
  output logic [15:0] r16_rd_data [NUM_R16_RD],
  input  logic        r8_wr_en,
  input  gp_r8_sel_t  r8_wr_sel,
  input  logic [7:0]  r8_wr_data,
  input  logic        r16_wr_en,
  input  logic        r16_wr_stk,
  input  logic [1:0]  r16_wr_sel,
  input  logic [15:0] r16_wr_data,
  input  logic        w_wr_en,
  input  logic [7:0]  w_wr_data,
  input  logic [3:0]  f_wr_mask,
  input  flags_t      f_wr_data,
  input  logic        idu_en,
  input  gp_r16_sel_t idu_sel,
  input  logic        idu_dec,
  input  logic        pc_wr_en,
  input  logic [15:0] pc_wr_data,
  input  logic        pc_inc,
  input  logic        ir_wr_en,
  input  logic [7:0]  ir_wr_data,
  input  logic        ie_wr_en,
  input  logic [7:0]  ie_wr_data,
  output logic [15:0] wz,
  output reg_vec_t    regs
);

  localparam reg_vec_t RST_VAL = POST_BOOT ? REGFILE_RST_BOOT : REGFILE_RST_ZERO;

  reg_vec_t    r_regs;
  reg_vec_t    w_nxt;
  reg_vec_t    w_view;
  idu_op_t     w_idu_op;
  pair_idx_t   w_wr_pair;
  logic [15:0] w_idu_in;
  logic [15:0] w_idu_out;
  logic [15:0] w_pc_inc;
  logic [3:0]  w_flags;

  assign w_flags = f_wr_data;

  always_comb begin
    w_idu_op = IDU_NONE;
    if (idu_en) w_idu_op = idu_dec ? IDU_DEC : IDU_INC;
  end

  always_comb begin
    case (idu_sel)
      R16_BC: w_idu_in = {r_regs.b, r_regs.c};
      R16_DE: w_idu_in = {r_regs.d, r_regs.e};
      R16_HL: w_idu_in = {r_regs.h, r_regs.l};
      R16_SP: w_idu_in = r_regs.sp;
    endcase
  end

  sm83_idu u_idu (
    .i_in  (w_idu_in),
    .i_dec (w_idu_op == IDU_DEC),
    .o_out (w_idu_out)
  );

  sm83_idu u_pc_idu (
    .i_in  (r_regs.pc),
    .i_dec (1'b0),
    .o_out (w_pc_inc)
  );

  always_comb begin
    if (r16_wr_stk) w_wr_pair = stk_to_idx(stk_r16_sel_t'(r16_wr_sel));
    else            w_wr_pair = pair_idx_t'({1'b0, r16_wr_sel});
  end

  // Sources applied lowest priority first, so each higher source overrides
  // only the bytes it actually writes.
  always_comb begin
    w_nxt = r_regs;
    if (w_idu_op != IDU_NONE) begin
      case (idu_sel)
        R16_BC: {w_nxt.b, w_nxt.c} = w_idu_out;
        R16_DE: {w_nxt.d, w_nxt.e} = w_idu_out;
        R16_HL: {w_nxt.h, w_nxt.l} = w_idu_out;
        R16_SP: w_nxt.sp           = w_idu_out;
      endcase
    end
    if (r16_wr_en) begin
      case (w_wr_pair)
        PAIR_BC: {w_nxt.b, w_nxt.c} = r16_wr_data;
        PAIR_DE: {w_nxt.d, w_nxt.e} = r16_wr_data;
        PAIR_HL: {w_nxt.h, w_nxt.l} = r16_wr_data;
        PAIR_SP: w_nxt.sp           = r16_wr_data;
        PAIR_AF: {w_nxt.a, w_nxt.f} = r16_wr_data;
        default: ;
      endcase
    end
    if (r8_wr_en) begin
      case (r8_wr_sel)
        REG_B: w_nxt.b = r8_wr_data;
        REG_C: w_nxt.c = r8_wr_data;
        REG_D: w_nxt.d = r8_wr_data;
        REG_E: w_nxt.e = r8_wr_data;
        REG_H: w_nxt.h = r8_wr_data;
        REG_L: w_nxt.l = r8_wr_data;
        REG_Z: w_nxt.z = r8_wr_data;
        REG_A: w_nxt.a = r8_wr_data;
      endcase
    end
    w_nxt.f[7:4] = (w_nxt.f[7:4] & ~f_wr_mask) | (w_flags & f_wr_mask);
    w_nxt.f[3:0] = '0;
    if (w_wr_en)  w_nxt.w  = w_wr_data;
    if (ir_wr_en) w_nxt.ir = ir_wr_data;
    if (ie_wr_en) w_nxt.ie = ie_wr_data;
    if (pc_wr_en)    w_nxt.pc = pc_wr_data;
    else if (pc_inc) w_nxt.pc = w_pc_inc;
    // Held in reset, forwarded reads must show reset values, not pending writes.
    if (rst) w_nxt = r_regs;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_regs <= RST_VAL;
    else     r_regs <= w_nxt;
  end

  if (BYPASS) begin : g_fwd
    assign w_view = w_nxt;
  end else begin : g_reg
    assign w_view = r_regs;
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_R8_RD; i++) begin
      r8_rd_data[i] = '0;
      case (r8_rd_sel[i])
        REG_B: r8_rd_data[i] = w_view.b;
        REG_C: r8_rd_data[i] = w_view.c;
        REG_D: r8_rd_data[i] = w_view.d;
        REG_E: r8_rd_data[i] = w_view.e;
        REG_H: r8_rd_data[i] = w_view.h;
        REG_L: r8_rd_data[i] = w_view.l;
        REG_Z: r8_rd_data[i] = w_view.z;
        REG_A: r8_rd_data[i] = w_view.a;
      endcase
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_R16_RD; i++) begin
      r16_rd_data[i] = '0;
      case (r16_rd_sel[i])
        R16_BC: r16_rd_data[i] = {w_view.b, w_view.c};
        R16_DE: r16_rd_data[i] = {w_view.d, w_view.e};
        R16_HL: r16_rd_data[i] = {w_view.h, w_view.l};
        R16_SP: r16_rd_data[i] = w_view.sp;
      endcase
    end
  end

  assign regs = r_regs;
  assign wz   = {r_regs.w, r_regs.z};

endmodule

// File: tb/tb_sm83_regfile_mp.sv
// Scoreboard bench: two register-file instances (forwarding/post-boot and registered/zero-reset).
module tb_sm83_regfile_mp;
  import sm83_pkg::*;

  typedef struct packed {
    logic [1:0][2:0] r8_rd_sel;
    logic [1:0][1:0] r16_rd_sel;
    logic            r8_wr_en;
    logic [2:0]      r8_wr_sel;
    logic [7:0]      r8_wr_data;
    logic            r16_wr_en;
    logic            r16_wr_stk;
    logic [1:0]      r16_wr_sel;
    logic [15:0]     r16_wr_data;
    logic            w_wr_en;
    logic [7:0]      w_wr_data;
    logic [3:0]      f_wr_mask;
    logic [3:0]      f_wr_data;
    logic            idu_en;
    logic [1:0]      idu_sel;
    logic            idu_dec;
    logic            pc_wr_en;
    logic [15:0]     pc_wr_data;
    logic            pc_inc;
    logic            ir_wr_en;
    logic [7:0]      ir_wr_data;
    logic            ie_wr_en;
    logic [7:0]      ie_wr_data;
  } txn_t;

  // Reference state: 16 bytes, r8 select codes index bytes 0..7 directly.
  typedef logic [15:0][7:0] mdl_t;
  localparam int IX_Z = 6, IX_A = 7, IX_F = 8, IX_W = 9, IX_IR = 10, IX_IE = 11;
  localparam int IX_SP = 12, IX_PC = 14;

  typedef struct {
    string                 tag;
    logic [1:0][1:0][7:0]  rd8;
    logic [1:0][1:0][15:0] rd16;
    reg_vec_t [1:0]        rv;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  gp_r8_sel_t  r8_rd_sel [2];
  logic [7:0]  rd8_0 [2];
  logic [7:0]  rd8_1 [2];
  gp_r16_sel_t r16_rd_sel [2];
  logic [15:0] rd16_0 [2];
  logic [15:0] rd16_1 [2];
  logic        r8_wr_en;
  gp_r8_sel_t  r8_wr_sel;
  logic [7:0]  r8_wr_data;
  logic        r16_wr_en, r16_wr_stk;
  logic [1:0]  r16_wr_sel;
  logic [15:0] r16_wr_data;
  logic        w_wr_en;
  logic [7:0]  w_wr_data;
  logic [3:0]  f_wr_mask;
  flags_t      f_wr_data;
  logic        idu_en;
  gp_r16_sel_t idu_sel;
  logic        idu_dec;
  logic        pc_wr_en;
  logic [15:0] pc_wr_data;
  logic        pc_inc;
  logic        ir_wr_en;
  logic [7:0]  ir_wr_data;
  logic        ie_wr_en;
  logic [7:0]  ie_wr_data;
  logic [15:0] wz0, wz1;
  reg_vec_t    regs0, regs1;

  exp_t q[$];
  mdl_t m0, m1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sm83_regfile_mp #(.NUM_R8_RD(2), .NUM_R16_RD(2), .BYPASS(1'b1), .POST_BOOT(1'b1)) dut (
    .clk(clk), .rst(rst),
    .r8_rd_sel(r8_rd_sel), .r8_rd_data(rd8_0),
    .r16_rd_sel(r16_rd_sel), .r16_rd_data(rd16_0),
    .r8_wr_en(r8_wr_en), .r8_wr_sel(r8_wr_sel), .r8_wr_data(r8_wr_data),
    .r16_wr_en(r16_wr_en), .r16_wr_stk(r16_wr_stk), .r16_wr_sel(r16_wr_sel),
    .r16_wr_data(r16_wr_data),
    .w_wr_en(w_wr_en), .w_wr_data(w_wr_data),
    .f_wr_mask(f_wr_mask), .f_wr_data(f_wr_data),
    .idu_en(idu_en), .idu_sel(idu_sel), .idu_dec(idu_dec),
    .pc_wr_en(pc_wr_en), .pc_wr_data(pc_wr_data), .pc_inc(pc_inc),
    .ir_wr_en(ir_wr_en), .ir_wr_data(ir_wr_data),
    .ie_wr_en(ie_wr_en), .ie_wr_data(ie_wr_data),
    .wz(wz0), .regs(regs0)
  );

  sm83_regfile_mp #(.NUM_R8_RD(2), .NUM_R16_RD(2), .BYPASS(1'b0), .POST_BOOT(1'b0)) dut_nb (
    .clk(clk), .rst(rst),
    .r8_rd_sel(r8_rd_sel), .r8_rd_data(rd8_1),
    .r16_rd_sel(r16_rd_sel), .r16_rd_data(rd16_1),
    .r8_wr_en(r8_wr_en), .r8_wr_sel(r8_wr_sel), .r8_wr_data(r8_wr_data),
    .r16_wr_en(r16_wr_en), .r16_wr_stk(r16_wr_stk), .r16_wr_sel(r16_wr_sel),
    .r16_wr_data(r16_wr_data),
    .w_wr_en(w_wr_en), .w_wr_data(w_wr_data),
    .f_wr_mask(f_wr_mask), .f_wr_data(f_wr_data),
    .idu_en(idu_en), .idu_sel(idu_sel), .idu_dec(idu_dec),
    .pc_wr_en(pc_wr_en), .pc_wr_data(pc_wr_data), .pc_inc(pc_inc),
    .ir_wr_en(ir_wr_en), .ir_wr_data(ir_wr_data),
    .ie_wr_en(ie_wr_en), .ie_wr_data(ie_wr_data),
    .wz(wz1), .regs(regs1)
  );

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endfunction

  function automatic int pair_hi(input logic stk, input logic [1:0] sel);
    if (sel == 2'd3) return stk ? IX_A : IX_SP;
    return 2 * int'(sel);
  endfunction

  function automatic logic [15:0] pget(input mdl_t m, input int h);
    return {m[h], m[h+1]};
  endfunction

  function automatic mdl_t boot_mdl();
    mdl_t m = '0;
    m[1] = 8'h13; m[3] = 8'hD8; m[4] = 8'h01; m[5] = 8'h4D;
    m[IX_A] = 8'h01; m[IX_F] = 8'hB0;
    m[IX_SP] = 8'hFF; m[IX_SP+1] = 8'hFE;
    m[IX_PC] = 8'h01; m[IX_PC+1] = 8'h00;
    return m;
  endfunction

  function automatic reg_vec_t to_rv(input mdl_t m);
    reg_vec_t r;
    r.a = m[IX_A]; r.f = m[IX_F];
    r.b = m[0]; r.c = m[1]; r.d = m[2]; r.e = m[3]; r.h = m[4]; r.l = m[5];
    r.sp = pget(m, IX_SP); r.pc = pget(m, IX_PC);
    r.w = m[IX_W]; r.z = m[IX_Z]; r.ir = m[IX_IR]; r.ie = m[IX_IE];
    return r;
  endfunction

  // Reference: weakest source first; later sources overwrite only their bytes.
  function automatic mdl_t model_next(input mdl_t m, input txn_t t);
    mdl_t        n = m;
    int          h;
    logic [15:0] v;
    if (t.idu_en) begin
      h = pair_hi(1'b0, t.idu_sel);
      v = pget(m, h);
      v = t.idu_dec ? v - 16'd1 : v + 16'd1;
      n[h] = v[15:8]; n[h+1] = v[7:0];
    end
    if (t.r16_wr_en) begin
      h = pair_hi(t.r16_wr_stk, t.r16_wr_sel);
      n[h] = t.r16_wr_data[15:8]; n[h+1] = t.r16_wr_data[7:0];
    end
    if (t.r8_wr_en) n[t.r8_wr_sel] = t.r8_wr_data;
    for (int k = 0; k < 4; k++)
      if (t.f_wr_mask[k]) n[IX_F][4+k] = t.f_wr_data[k];
    n[IX_F][3:0] = 4'h0;
    if (t.w_wr_en)  n[IX_W]  = t.w_wr_data;
    if (t.ir_wr_en) n[IX_IR] = t.ir_wr_data;
    if (t.ie_wr_en) n[IX_IE] = t.ie_wr_data;
    v = pget(m, IX_PC);
    if (t.pc_wr_en)    v = t.pc_wr_data;
    else if (t.pc_inc) v = v + 16'd1;
    n[IX_PC] = v[15:8]; n[IX_PC+1] = v[7:0];
    return n;
  endfunction

  task automatic drive(input txn_t t);
    for (int p = 0; p < 2; p++) begin
      r8_rd_sel[p]  = gp_r8_sel_t'(t.r8_rd_sel[p]);
      r16_rd_sel[p] = gp_r16_sel_t'(t.r16_rd_sel[p]);
    end
    r8_wr_en = t.r8_wr_en; r8_wr_sel = gp_r8_sel_t'(t.r8_wr_sel); r8_wr_data = t.r8_wr_data;
    r16_wr_en = t.r16_wr_en; r16_wr_stk = t.r16_wr_stk;
    r16_wr_sel = t.r16_wr_sel; r16_wr_data = t.r16_wr_data;
    w_wr_en = t.w_wr_en; w_wr_data = t.w_wr_data;
    f_wr_mask = t.f_wr_mask; f_wr_data = flags_t'(t.f_wr_data);
    idu_en = t.idu_en; idu_sel = gp_r16_sel_t'(t.idu_sel); idu_dec = t.idu_dec;
    pc_wr_en = t.pc_wr_en; pc_wr_data = t.pc_wr_data; pc_inc = t.pc_inc;
    ir_wr_en = t.ir_wr_en; ir_wr_data = t.ir_wr_data;
    ie_wr_en = t.ie_wr_en; ie_wr_data = t.ie_wr_data;
  endtask

  // Called 2 time units after a rising edge; returns at the same phase one cycle later.
  task automatic issue(input txn_t t, input string tag);
    exp_t e;
    mdl_t n0, n1;
    drive(t);
    n0 = model_next(m0, t);
    n1 = model_next(m1, t);
    e.tag = tag;
    for (int p = 0; p < 2; p++) begin
      e.rd8[0][p]  = n0[t.r8_rd_sel[p]];
      e.rd8[1][p]  = m1[t.r8_rd_sel[p]];
      e.rd16[0][p] = pget(n0, pair_hi(1'b0, t.r16_rd_sel[p]));
      e.rd16[1][p] = pget(m1, pair_hi(1'b0, t.r16_rd_sel[p]));
    end
    e.rv[0] = to_rv(n0);
    e.rv[1] = to_rv(n1);
    q.push_back(e);
    m0 = n0;
    m1 = n1;
    @(posedge clk);
    #2;
  endtask

  function automatic txn_t rand_txn();
    txn_t t = '0;
    t.r8_rd_sel  = 6'($urandom);
    t.r16_rd_sel = 4'($urandom);
    t.r8_wr_en = 1'($urandom); t.r8_wr_sel = 3'($urandom); t.r8_wr_data = 8'($urandom);
    t.r16_wr_en = 1'($urandom); t.r16_wr_stk = 1'($urandom);
    t.r16_wr_sel = 2'($urandom); t.r16_wr_data = 16'($urandom);
    t.w_wr_en = 1'($urandom); t.w_wr_data = 8'($urandom);
    t.f_wr_mask = 4'($urandom); t.f_wr_data = 4'($urandom);
    t.idu_en = 1'($urandom); t.idu_sel = 2'($urandom); t.idu_dec = 1'($urandom);
    t.pc_wr_en = ($urandom_range(0, 3) == 0); t.pc_wr_data = 16'($urandom);
    t.pc_inc = 1'($urandom);
    t.ir_wr_en = 1'($urandom); t.ir_wr_data = 8'($urandom);
    t.ie_wr_en = 1'($urandom); t.ie_wr_data = 8'($urandom);
    return t;
  endfunction

  // Monitor: read ports sampled mid-cycle, registered outputs just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q[0];
        for (int p = 0; p < 2; p++) begin
          chk($sformatf("%s rd8[%0d] fwd", e.tag, p), rd8_0[p], e.rd8[0][p]);
          chk($sformatf("%s rd8[%0d] reg", e.tag, p), rd8_1[p], e.rd8[1][p]);
          chk($sformatf("%s rd16[%0d] fwd", e.tag, p), rd16_0[p], e.rd16[0][p]);
          chk($sformatf("%s rd16[%0d] reg", e.tag, p), rd16_1[p], e.rd16[1][p]);
        end
        @(posedge clk);
        #1;
        chk({e.tag, " regs fwd"}, regs0, e.rv[0]);
        chk({e.tag, " regs reg"}, regs1, e.rv[1]);
        chk({e.tag, " wz fwd"}, wz0, {e.rv[0].w, e.rv[0].z});
        chk({e.tag, " wz reg"}, wz1, {e.rv[1].w, e.rv[1].z});
        void'(q.pop_front());
      end
    end
  end

  initial begin
    txn_t t;
    drive('0);
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("async reset regs boot", regs0, to_rv(boot_mdl()));
    chk("async reset regs zero", regs1, to_rv('0));
    chk("async reset bc read", rd16_0[0], 16'h0013);
    chk("async reset wz", wz0, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    m0 = boot_mdl();
    m1 = '0;

    t = '0; t.r16_wr_en = 1; t.r16_wr_sel = 2'd2; t.r16_wr_data = 16'hFFFF;
    issue(t, "hl=ffff");
    t = '0; t.idu_en = 1; t.idu_sel = 2'd2; t.r16_rd_sel[0] = 2'd2;
    issue(t, "hl+ wrap");
    t = '0; t.idu_en = 1; t.idu_sel = 2'd2; t.idu_dec = 1; t.r16_rd_sel[1] = 2'd2;
    issue(t, "hl- wrap");
    t = '0; t.r16_wr_en = 1; t.r16_wr_sel = 2'd3; t.r16_wr_data = 16'h1234;
    t.idu_en = 1; t.idu_sel = 2'd3; t.idu_dec = 1; t.r16_rd_sel[0] = 2'd3;
    issue(t, "sp r16 over idu");
    t = '0; t.r8_wr_en = 1; t.r8_wr_sel = 3'd4; t.r8_wr_data = 8'hAA;
    t.r16_wr_en = 1; t.r16_wr_sel = 2'd2; t.r16_wr_data = 16'h1234; t.r16_rd_sel[0] = 2'd2;
    issue(t, "h/hl merge");
    t = '0; t.f_wr_mask = 4'b1000; t.f_wr_data = 4'b0111;
    t.r16_wr_en = 1; t.r16_wr_stk = 1; t.r16_wr_sel = 2'd3; t.r16_wr_data = 16'h12FF;
    t.r8_rd_sel[0] = 3'd7;
    issue(t, "f/af merge");
    t = '0; t.r8_wr_en = 1; t.r8_wr_sel = 3'd0; t.r8_wr_data = 8'h5A;
    issue(t, "b fwd");
    t = '0;
    issue(t, "b after");
    t = '0; t.pc_wr_en = 1; t.pc_wr_data = 16'hFFFF;
    issue(t, "pc=ffff");
    t = '0; t.pc_inc = 1;
    issue(t, "pc wrap");
    t = '0; t.pc_wr_en = 1; t.pc_wr_data = 16'h0200; t.pc_inc = 1;
    issue(t, "pc load over inc");
    t = '0; t.w_wr_en = 1; t.w_wr_data = 8'hC3;
    t.r8_wr_en = 1; t.r8_wr_sel = 3'd6; t.r8_wr_data = 8'h50; t.r8_rd_sel[1] = 3'd6;
    issue(t, "wz");

    for (int i = 0; i < 400; i++) issue(rand_txn(), $sformatf("rand%0d", i));

    drive('0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    chk("queue drained", q.size(), 0);

    t = '0; t.r8_wr_en = 1; t.r8_wr_sel = 3'd1; t.r8_wr_data = 8'h77;
    t.r16_wr_en = 1; t.r16_wr_sel = 2'd1; t.r16_wr_data = 16'h5555;
    t.pc_wr_en = 1; t.pc_wr_data = 16'h1234; t.r8_rd_sel[0] = 3'd1;
    drive(t);
    rst = 1'b1;
    #1;
    chk("mid reset regs boot", regs0, to_rv(boot_mdl()));
    chk("mid reset regs zero", regs1, to_rv('0));
    chk("mid reset c fwd", rd8_0[0], 8'h13);
    chk("mid reset c reg", rd8_1[0], 8'h00);
    chk("mid reset bc fwd", rd16_0[0], 16'h0013);
    @(posedge clk);
    #1;
    chk("held reset regs boot", regs0, to_rv(boot_mdl()));
    chk("held reset regs zero", regs1, to_rv('0));
    #1;
    rst = 1'b0;
    m0 = boot_mdl();
    m1 = '0;
    t = '0; t.r16_wr_en = 1; t.r16_wr_sel = 2'd1; t.r16_wr_data = 16'hBEEF;
    t.r8_rd_sel[0] = 3'd2;
    issue(t, "first write after reset");
    t = '0; t.r16_rd_sel[0] = 2'd1;
    issue(t, "de readback");
    drive('0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    chk("final queue drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
